// File: rtl/nv_nvdla_csc_mac_tx.sv
// -----------------------------------------------------------------------------
// nv_nvdla_csc_mac_tx
//
// CSC-side sender for the sc2mac weight/data interface. One stripe command is
// accepted in IDLE. The stripe's weight kernels are forwarded first (WT), then
// its data atoms (DAT), after which the block returns to IDLE. The output side
// is valid-only, so there is no backpressure. Every sc2mac_* output comes
// straight from a flop and lags the input handshake by one cycle.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn   clock, async active-low reset
//   cmd_vld/cmd_rdy + cmd_*            stripe command (len-1, kernels, batch,
//                                      channel/layer end flags)
//   wt_in_vld/rdy, wt_in_data/mask     weight atom input (ready only in WT)
//   dat_in_vld/rdy, dat_in_data/mask   data atom input (ready only in DAT)
//   sc2mac_wt_pvld/mask/data/sel       weight beat out, one-hot kernel slot
//   sc2mac_dat_pvld/mask/data/pd       data beat out, pd = stripe info
//   busy                               high whenever the FSM is not IDLE
//
// Configuration macro: NVDLA_CSC_TX_MASK_HOLD_EN
//   defined   : a lane register loads only when its beat is accepted and its
//               mask bit is set. Masked lanes keep their stale value.
//   undefined : all lanes load on every accepted beat. Masked lanes read 0.
// -----------------------------------------------------------------------------
module nv_nvdla_csc_mac_tx #(
  parameter int CMAC_ATOMC      = 8,
  parameter int CMAC_BPE        = 8,
  parameter int CMAC_ATOMK_HALF = 4,
  parameter int STRIPE_W        = 7,
  parameter int KW              = 3
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rstn,
  input  logic                           cmd_vld,
  output logic                           cmd_rdy,
  input  logic [STRIPE_W-1:0]            cmd_stripe_len,
  input  logic [KW-1:0]                  cmd_wt_kernels,
  input  logic [4:0]                     cmd_batch,
  input  logic                           cmd_channel_end,
  input  logic                           cmd_layer_end,
  input  logic                           wt_in_vld,
  output logic                           wt_in_rdy,
  input  logic [CMAC_BPE*CMAC_ATOMC-1:0] wt_in_data,
  input  logic [CMAC_ATOMC-1:0]          wt_in_mask,
  input  logic                           dat_in_vld,
  output logic                           dat_in_rdy,
  input  logic [CMAC_BPE*CMAC_ATOMC-1:0] dat_in_data,
  input  logic [CMAC_ATOMC-1:0]          dat_in_mask,
  output logic                           sc2mac_wt_pvld,
  output logic [CMAC_ATOMC-1:0]          sc2mac_wt_mask,
  output logic [CMAC_BPE*CMAC_ATOMC-1:0] sc2mac_wt_data,
  output logic [CMAC_ATOMK_HALF-1:0]     sc2mac_wt_sel,
  output logic                           sc2mac_dat_pvld,
  output logic [CMAC_ATOMC-1:0]          sc2mac_dat_mask,
  output logic [CMAC_BPE*CMAC_ATOMC-1:0] sc2mac_dat_data,
  output logic [8:0]                     sc2mac_dat_pd,
  output logic                           busy
);

  localparam int DW = CMAC_BPE * CMAC_ATOMC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WT   = 2'd1,
    ST_DAT  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          kcnt_q, kcnt_d;
  logic [STRIPE_W-1:0]    acnt_q, acnt_d;

  // Latched command fields
  logic [KW-1:0]          kn_q;
  logic [STRIPE_W-1:0]    len_q;
  logic [4:0]             batch_q;
  logic                   ch_end_q;
  logic                   layer_end_q;

  // Output registers
  logic                   wt_pvld_q;
  logic [CMAC_ATOMC-1:0]  wt_mask_q;
  logic [DW-1:0]          wt_data_q;
  logic [CMAC_ATOMK_HALF-1:0] wt_sel_q;
  logic                   dat_pvld_q;
  logic [CMAC_ATOMC-1:0]  dat_mask_q;
  logic [DW-1:0]          dat_data_q;
  logic [8:0]             dat_pd_q;

  logic                   cmd_acc_s;
  logic                   wt_acc_s;
  logic                   dat_acc_s;
  logic [KW-1:0]          kn_clip_s;
  logic                   stripe_end_s;
  logic [8:0]             pd_s;
  logic [CMAC_ATOMK_HALF-1:0] sel_s;

  // Handshake decode. The ready signals come only from the state register.
  always_comb begin
    cmd_rdy    = (state_q == ST_IDLE);
    wt_in_rdy  = (state_q == ST_WT);
    dat_in_rdy = (state_q == ST_DAT);
    busy       = (state_q != ST_IDLE);
    cmd_acc_s  = cmd_vld    && cmd_rdy;
    wt_acc_s   = wt_in_vld  && wt_in_rdy;
    dat_acc_s  = dat_in_vld && dat_in_rdy;
  end

  // Clip the kernel count and build the per-beat sideband (sel, pd)
  always_comb begin
    if (cmd_wt_kernels > KW'(CMAC_ATOMK_HALF)) begin
      kn_clip_s = KW'(CMAC_ATOMK_HALF);
    end else begin
      kn_clip_s = cmd_wt_kernels;
    end
    stripe_end_s = (acnt_q == len_q);
    sel_s        = {{(CMAC_ATOMK_HALF-1){1'b0}}, 1'b1} << kcnt_q;
    pd_s         = {layer_end_q & stripe_end_s,
                    ch_end_q & stripe_end_s,
                    stripe_end_s,
                    (acnt_q == {STRIPE_W{1'b0}}),
                    batch_q};
  end

  // Next-state logic for the stripe FSM and its beat counters
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    acnt_d  = acnt_q;
    case (state_q)
      ST_IDLE: begin
        kcnt_d = {KW{1'b0}};
        acnt_d = {STRIPE_W{1'b0}};
        if (cmd_vld) begin
          // A zero kernel count reuses the weights already held by CMAC
          state_d = (kn_clip_s != {KW{1'b0}}) ? ST_WT : ST_DAT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WT: begin
        if (wt_in_vld) begin
          if (kcnt_q == (kn_q - KW'(1))) begin
            state_d = ST_DAT;
            kcnt_d  = {KW{1'b0}};
          end else begin
            kcnt_d  = kcnt_q + KW'(1);
          end
        end else begin
          state_d = ST_WT;
        end
      end
      ST_DAT: begin
        if (dat_in_vld) begin
          if (stripe_end_s) begin
            state_d = ST_IDLE;
            acnt_d  = {STRIPE_W{1'b0}};
          end else begin
            acnt_d  = acnt_q + STRIPE_W'(1);
          end
        end else begin
          state_d = ST_DAT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        kcnt_d  = {KW{1'b0}};
        acnt_d  = {STRIPE_W{1'b0}};
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= ST_IDLE;
      kcnt_q  <= {KW{1'b0}};
      acnt_q  <= {STRIPE_W{1'b0}};
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      acnt_q  <= acnt_d;
    end
  end

  // Command field capture on an accepted command
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      kn_q        <= {KW{1'b0}};
      len_q       <= {STRIPE_W{1'b0}};
      batch_q     <= 5'd0;
      ch_end_q    <= 1'b0;
      layer_end_q <= 1'b0;
    end else if (cmd_acc_s) begin
      kn_q        <= kn_clip_s;
      len_q       <= cmd_stripe_len;
      batch_q     <= cmd_batch;
      ch_end_q    <= cmd_channel_end;
      layer_end_q <= cmd_layer_end;
    end
  end

  // Output valids and sideband. Mask, sel and pd hold through bubbles.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wt_pvld_q  <= 1'b0;
      wt_mask_q  <= {CMAC_ATOMC{1'b0}};
      wt_sel_q   <= {CMAC_ATOMK_HALF{1'b0}};
      dat_pvld_q <= 1'b0;
      dat_mask_q <= {CMAC_ATOMC{1'b0}};
      dat_pd_q   <= 9'd0;
    end else begin
      wt_pvld_q  <= wt_acc_s;
      dat_pvld_q <= dat_acc_s;
      if (wt_acc_s) begin
        wt_mask_q <= wt_in_mask;
        wt_sel_q  <= sel_s;
      end
      if (dat_acc_s) begin
        dat_mask_q <= dat_in_mask;
        dat_pd_q   <= pd_s;
      end
    end
  end

`ifdef NVDLA_CSC_TX_MASK_HOLD_EN
  // Lane data registers: only unmasked lanes of an accepted beat load
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wt_data_q  <= {DW{1'b0}};
      dat_data_q <= {DW{1'b0}};
    end else begin
      for (int k = 0; k < CMAC_ATOMC; k++) begin
        if (wt_acc_s && wt_in_mask[k]) begin
          wt_data_q[k*CMAC_BPE +: CMAC_BPE] <= wt_in_data[k*CMAC_BPE +: CMAC_BPE];
        end
        if (dat_acc_s && dat_in_mask[k]) begin
          dat_data_q[k*CMAC_BPE +: CMAC_BPE] <= dat_in_data[k*CMAC_BPE +: CMAC_BPE];
        end
      end
    end
  end
`else
  // Spread a lane mask to a bit mask covering each lane's CMAC_BPE bits
  function automatic logic [DW-1:0] lane_expand(input logic [CMAC_ATOMC-1:0] m);
    logic [DW-1:0] r;
    r = {DW{1'b0}};
    for (int k = 0; k < CMAC_ATOMC; k++) begin
      r[k*CMAC_BPE +: CMAC_BPE] = {CMAC_BPE{m[k]}};
    end
    return r;
  endfunction

  // Lane data registers: every lane loads, masked lanes are zeroed
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wt_data_q  <= {DW{1'b0}};
      dat_data_q <= {DW{1'b0}};
    end else begin
      if (wt_acc_s) begin
        wt_data_q <= wt_in_data & lane_expand(wt_in_mask);
      end
      if (dat_acc_s) begin
        dat_data_q <= dat_in_data & lane_expand(dat_in_mask);
      end
    end
  end
`endif

  assign sc2mac_wt_pvld  = wt_pvld_q;
  assign sc2mac_wt_mask  = wt_mask_q;
  assign sc2mac_wt_data  = wt_data_q;
  assign sc2mac_wt_sel   = wt_sel_q;
  assign sc2mac_dat_pvld = dat_pvld_q;
  assign sc2mac_dat_mask = dat_mask_q;
  assign sc2mac_dat_data = dat_data_q;
  assign sc2mac_dat_pd   = dat_pd_q;

endmodule

// File: tb/tb_nv_nvdla_csc_mac_tx.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for nv_nvdla_csc_mac_tx. Stimulus tasks push the expected
// output beat when the input beat is accepted. A monitor pops the expected beat
// and compares it whenever the DUT shows pvld.
// -----------------------------------------------------------------------------
module tb_nv_nvdla_csc_mac_tx;

  logic        clk;
  logic        rstn;
  logic        cmd_vld, cmd_rdy;
  logic [6:0]  cmd_stripe_len;
  logic [2:0]  cmd_wt_kernels;
  logic [4:0]  cmd_batch;
  logic        cmd_channel_end, cmd_layer_end;
  logic        wt_in_vld, wt_in_rdy;
  logic [63:0] wt_in_data;
  logic [7:0]  wt_in_mask;
  logic        dat_in_vld, dat_in_rdy;
  logic [63:0] dat_in_data;
  logic [7:0]  dat_in_mask;
  logic        wt_pvld, dat_pvld, busy;
  logic [7:0]  wt_mask, dat_mask;
  logic [63:0] wt_data, dat_data;
  logic [3:0]  wt_sel;
  logic [8:0]  dat_pd;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [3:0] sel; logic [7:0] mask; logic [63:0] data; } wt_exp_t;
  typedef struct { logic [8:0] pd;  logic [7:0] mask; logic [63:0] data; } dat_exp_t;
  wt_exp_t  wq[$];
  dat_exp_t dq[$];

  nv_nvdla_csc_mac_tx dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_stripe_len  (cmd_stripe_len),
    .cmd_wt_kernels  (cmd_wt_kernels),
    .cmd_batch       (cmd_batch),
    .cmd_channel_end (cmd_channel_end),
    .cmd_layer_end   (cmd_layer_end),
    .wt_in_vld       (wt_in_vld),
    .wt_in_rdy       (wt_in_rdy),
    .wt_in_data      (wt_in_data),
    .wt_in_mask      (wt_in_mask),
    .dat_in_vld      (dat_in_vld),
    .dat_in_rdy      (dat_in_rdy),
    .dat_in_data     (dat_in_data),
    .dat_in_mask     (dat_in_mask),
    .sc2mac_wt_pvld  (wt_pvld),
    .sc2mac_wt_mask  (wt_mask),
    .sc2mac_wt_data  (wt_data),
    .sc2mac_wt_sel   (wt_sel),
    .sc2mac_dat_pvld (dat_pvld),
    .sc2mac_dat_mask (dat_mask),
    .sc2mac_dat_data (dat_data),
    .sc2mac_dat_pd   (dat_pd),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected beat at %0t", name, $time);
  endtask

  // Monitor: compare every presented beat against the scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        if (wt_pvld) begin
          if (wq.size() == 0) begin
            bound_fail("wt_unexpected");
          end else begin
            wt_exp_t e;
            e = wq.pop_front();
            chk("wt_sel",  64'(wt_sel),  64'(e.sel));
            chk("wt_mask", 64'(wt_mask), 64'(e.mask));
            chk("wt_data", wt_data,      e.data);
          end
        end
        if (dat_pvld) begin
          if (dq.size() == 0) begin
            bound_fail("dat_unexpected");
          end else begin
            dat_exp_t e;
            e = dq.pop_front();
            chk("dat_pd",   64'(dat_pd),   64'(e.pd));
            chk("dat_mask", 64'(dat_mask), 64'(e.mask));
            chk("dat_data", dat_data,      e.data);
          end
        end
      end
    end
  end

  // All tasks start and end at a negedge
  task automatic send_cmd(input logic [2:0] k, input logic [6:0] len, input logic [4:0] b,
                          input logic ce, input logic le);
    int t;
    t = 0;
    cmd_vld = 1'b1; cmd_wt_kernels = k; cmd_stripe_len = len;
    cmd_batch = b; cmd_channel_end = ce; cmd_layer_end = le;
    while (!cmd_rdy && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) bound_fail("cmd_wait");
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wt_beat(input logic [63:0] d, input logic [7:0] m,
                         input logic [3:0] sel, input logic [63:0] exp_d);
    int t;
    wt_exp_t e;
    t = 0;
    wt_in_vld = 1'b1; wt_in_data = d; wt_in_mask = m;
    while (!wt_in_rdy && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) bound_fail("wt_wait");
    e.sel = sel; e.mask = m; e.data = exp_d;
    wq.push_back(e);
    @(negedge clk);
    wt_in_vld = 1'b0;
  endtask

  task automatic dat_beat(input logic [63:0] d, input logic [7:0] m,
                          input logic [8:0] pd, input logic [63:0] exp_d);
    int t;
    dat_exp_t e;
    t = 0;
    dat_in_vld = 1'b1; dat_in_data = d; dat_in_mask = m;
    while (!dat_in_rdy && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) bound_fail("dat_wait");
    e.pd = pd; e.mask = m; e.data = exp_d;
    dq.push_back(e);
    @(negedge clk);
    dat_in_vld = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    cmd_vld = 1'b0; cmd_stripe_len = 7'd0; cmd_wt_kernels = 3'd0; cmd_batch = 5'd0;
    cmd_channel_end = 1'b0; cmd_layer_end = 1'b0;
    wt_in_vld = 1'b0; wt_in_data = 64'd0; wt_in_mask = 8'd0;
    dat_in_vld = 1'b0; dat_in_data = 64'd0; dat_in_mask = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wt_pvld",  64'(wt_pvld),  64'd0);
    chk("rst_dat_pvld", 64'(dat_pvld), 64'd0);
    chk("rst_sel",      64'(wt_sel),   64'd0);
    chk("rst_pd",       64'(dat_pd),   64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_cmd_rdy",  64'(cmd_rdy),  64'd1);
    rstn = 1'b1;
    @(negedge clk);

    // T1: two kernels, three data atoms, channel end
    send_cmd(3'd2, 7'd2, 5'd3, 1'b1, 1'b0);
    wt_beat(64'h2222_2222_2222_2222, 8'hFF, 4'b0001, 64'h2222_2222_2222_2222);
`ifdef NVDLA_CSC_TX_MASK_HOLD_EN
    wt_beat(64'h1111_1111_1111_1111, 8'h0F, 4'b0010, 64'h2222_2222_1111_1111);
`else
    wt_beat(64'h1111_1111_1111_1111, 8'h0F, 4'b0010, 64'h0000_0000_1111_1111);
`endif
    dat_beat(64'h0102_0304_0506_0708, 8'hFF, 9'h023, 64'h0102_0304_0506_0708);
    dat_beat(64'h1112_1314_1516_1718, 8'hFF, 9'h003, 64'h1112_1314_1516_1718);
    dat_beat(64'h2122_2324_2526_2728, 8'hFF, 9'h0C3, 64'h2122_2324_2526_2728);
    chk("t1_busy_drop", 64'(busy), 64'd0);

    // T2: weight reuse, single-atom stripe, layer end
    send_cmd(3'd0, 7'd0, 5'd0, 1'b0, 1'b1);
    chk("t2_no_wt_rdy", 64'(wt_in_rdy), 64'd0);
    dat_beat(64'hDEAD_BEEF_0123_4567, 8'hFF, 9'h160, 64'hDEAD_BEEF_0123_4567);
    chk("t2_cmd_rdy", 64'(cmd_rdy), 64'd1);

    // T3: bubble between data beats, sideband holds
    send_cmd(3'd0, 7'd2, 5'd5, 1'b0, 1'b0);
    dat_beat(64'hA0A1_A2A3_A4A5_A6A7, 8'hFF, 9'h025, 64'hA0A1_A2A3_A4A5_A6A7);
    @(negedge clk);
    chk("t3_gap_pvld", 64'(dat_pvld), 64'd0);
    chk("t3_gap_pd",   64'(dat_pd),   64'h025);
    chk("t3_gap_mask", 64'(dat_mask), 64'hFF);
    dat_beat(64'hB0B1_B2B3_B4B5_B6B7, 8'hFF, 9'h005, 64'hB0B1_B2B3_B4B5_B6B7);
    dat_beat(64'hC0C1_C2C3_C4C5_C6C7, 8'hFF, 9'h045, 64'hC0C1_C2C3_C4C5_C6C7);

    // T4: partial mask on the second beat
    send_cmd(3'd0, 7'd1, 5'd1, 1'b0, 1'b0);
    dat_beat(64'h5555_5555_5555_5555, 8'hFF, 9'h021, 64'h5555_5555_5555_5555);
`ifdef NVDLA_CSC_TX_MASK_HOLD_EN
    dat_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'h05, 9'h041, 64'h5555_5555_55AA_55AA);
`else
    dat_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'h05, 9'h041, 64'h0000_0000_00AA_00AA);
`endif

    // T6: kernel count clipped to four slots
    send_cmd(3'd7, 7'd0, 5'd2, 1'b0, 1'b0);
    wt_beat(64'h0000_0000_0000_0001, 8'hFF, 4'b0001, 64'h0000_0000_0000_0001);
    wt_beat(64'h0000_0000_0000_0002, 8'hFF, 4'b0010, 64'h0000_0000_0000_0002);
    wt_beat(64'h0000_0000_0000_0003, 8'hFF, 4'b0100, 64'h0000_0000_0000_0003);
    wt_beat(64'h0000_0000_0000_0004, 8'hFF, 4'b1000, 64'h0000_0000_0000_0004);
    chk("t6_wt_rdy_off", 64'(wt_in_rdy),  64'd0);
    chk("t6_dat_rdy_on", 64'(dat_in_rdy), 64'd1);
    dat_beat(64'h7777_7777_7777_7777, 8'hFF, 9'h062, 64'h7777_7777_7777_7777);

    // T5: reset after the first data beat of a four-atom stripe
    send_cmd(3'd0, 7'd3, 5'd4, 1'b0, 1'b0);
    dat_beat(64'h9999_9999_9999_9999, 8'hFF, 9'h024, 64'h9999_9999_9999_9999);
    rstn = 1'b0;
    #1;
    chk("t5_rst_pvld", 64'(dat_pvld), 64'd0);
    chk("t5_rst_busy", 64'(busy),     64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t5_cmd_rdy", 64'(cmd_rdy), 64'd1);
    send_cmd(3'd0, 7'd1, 5'd4, 1'b0, 1'b0);
    dat_beat(64'h8888_8888_8888_8888, 8'hFF, 9'h024, 64'h8888_8888_8888_8888);
    dat_beat(64'h6666_6666_6666_6666, 8'hFF, 9'h044, 64'h6666_6666_6666_6666);

    // Drain and confirm every expected beat was seen
    repeat (3) @(negedge clk);
    chk("wt_q_drained",  64'(wq.size()), 64'd0);
    chk("dat_q_drained", 64'(dq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
